// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_pkg
// Description : Shared types for the MEM-stage data-memory access engine.
//               Contents:
//                 - mem_op_enum        : access size and signedness.
//                 - mem_fsm_state_enum : states of the access sequencer.
//                 - MEM_BYTES()        : bytes moved by each access size.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

    localparam int c_BUS_BYTES = 8;

    typedef enum logic [2:0] {
        MEM_NO = 3'd0,
        MEM_B  = 3'd1,
        MEM_H  = 3'd2,
        MEM_W  = 3'd3,
        MEM_D  = 3'd4,
        MEM_UB = 3'd5,
        MEM_UH = 3'd6,
        MEM_UW = 3'd7
    } mem_op_enum;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_REQ  = 2'd1,
        MS_WAIT = 2'd2,
        MS_DONE = 2'd3
    } mem_fsm_state_enum;

    // Number of bytes moved by an access; MEM_NO moves nothing.
    function automatic logic [3:0] MEM_BYTES(input mem_op_enum op);
        case (op)
            MEM_B, MEM_UB: MEM_BYTES = 4'd1;
            MEM_H, MEM_UH: MEM_BYTES = 4'd2;
            MEM_W, MEM_UW: MEM_BYTES = 4'd4;
            MEM_D:         MEM_BYTES = 4'd8;
            default:       MEM_BYTES = 4'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_data_align
// Description : Combinational byte-lane steering for a 64-bit data bus.
//   Ports:
//     st_op_i, st_off_i, st_wdata_i : incoming access (store/check path)
//     st_mask_o, st_data_o          : byte mask and lane-shifted store data
//     misaligned_o                  : incoming access not naturally aligned
//     ld_op_i, ld_off_i, ld_data_i  : registered access + raw bus response
//     ld_data_o                     : extracted, sign/zero-extended load data
// Revision    : 1.0 - initial release
// ============================================================================
module mem_data_align
    import mem_access_unit_pkg::*;
(
    input  mem_op_enum  st_op_i,
    input  logic [2:0]  st_off_i,
    input  logic [63:0] st_wdata_i,
    output logic [7:0]  st_mask_o,
    output logic [63:0] st_data_o,
    output logic        misaligned_o,
    input  mem_op_enum  ld_op_i,
    input  logic [2:0]  ld_off_i,
    input  logic [63:0] ld_data_i,
    output logic [63:0] ld_data_o
);

    logic [7:0]  w_lanes;
    logic [63:0] w_raw;

    always_comb begin
        case (MEM_BYTES(st_op_i))
            4'd1:    w_lanes = 8'h01;
            4'd2:    w_lanes = 8'h03;
            4'd4:    w_lanes = 8'h0F;
            4'd8:    w_lanes = 8'hFF;
            default: w_lanes = 8'h00;
        endcase
        // Only aligned accesses are issued, so the shifted mask never
        // spills past lane 7.
        st_mask_o = w_lanes << st_off_i;
        st_data_o = st_wdata_i << {st_off_i, 3'b000};
    end

    always_comb begin
        case (st_op_i)
            MEM_H, MEM_UH: misaligned_o = st_off_i[0];
            MEM_W, MEM_UW: misaligned_o = (st_off_i[1:0] != 2'b00);
            MEM_D:         misaligned_o = (st_off_i != 3'b000);
            default:       misaligned_o = 1'b0;
        endcase
    end

    always_comb begin
        w_raw = ld_data_i >> {ld_off_i, 3'b000};
        case (ld_op_i)
            MEM_B:   ld_data_o = {{56{w_raw[7]}},  w_raw[7:0]};
            MEM_H:   ld_data_o = {{48{w_raw[15]}}, w_raw[15:0]};
            MEM_W:   ld_data_o = {{32{w_raw[31]}}, w_raw[31:0]};
            MEM_UB:  ld_data_o = {56'd0, w_raw[7:0]};
            MEM_UH:  ld_data_o = {48'd0, w_raw[15:0]};
            MEM_UW:  ld_data_o = {32'd0, w_raw[31:0]};
            MEM_D:   ld_data_o = w_raw;
            default: ld_data_o = 64'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : MEM-stage data-memory access engine. Issues one byte-masked,
//               doubleword-aligned bus request per load/store, waits for the
//               response, returns extended load data and stalls the pipeline
//               until the access completes. Misaligned accesses are flagged
//               and never issued.
//   Ports:
//     clk, rst                         : clock, synchronous active-high reset
//     req_valid_i/we_i/mem_op_i/addr_i/wdata_i : access from the MEM stage
//     stall_o, done_o, rdata_o, misaligned_o   : pipeline-side results
//     mem_req_valid_o/mem_req_ready_i          : bus request handshake
//     mem_addr_o, mem_we_o, mem_wdata_o, mem_wmask_o : bus request fields
//     mem_resp_valid_i, mem_resp_data_i        : bus response / store ack
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    input  logic                  req_we_i,
    input  mem_op_enum            req_mem_op_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  stall_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  misaligned_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [7:0]            mem_wmask_o,
    input  logic                  mem_resp_valid_i,
    input  logic [DATA_WIDTH-1:0] mem_resp_data_i
);

    mem_fsm_state_enum     state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    mem_op_enum            op_q;
    logic [2:0]            off_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [7:0]            wmask_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  w_accept;
    logic                  w_misal;
    logic [7:0]            w_st_mask;
    logic [DATA_WIDTH-1:0] w_st_data;
    logic [DATA_WIDTH-1:0] w_ld_data;

    mem_data_align u_align (
        .st_op_i      (req_mem_op_i),
        .st_off_i     (req_addr_i[2:0]),
        .st_wdata_i   (req_wdata_i),
        .st_mask_o    (w_st_mask),
        .st_data_o    (w_st_data),
        .misaligned_o (w_misal),
        .ld_op_i      (op_q),
        .ld_off_i     (off_q),
        .ld_data_i    (mem_resp_data_i),
        .ld_data_o    (w_ld_data)
    );

    always_comb begin
        state_d         = state_q;
        stall_o         = 1'b0;
        done_o          = 1'b0;
        misaligned_o    = 1'b0;
        mem_req_valid_o = 1'b0;
        w_accept        = 1'b0;
        case (state_q)
            MS_IDLE: begin
                if (req_valid_i) begin
                    if (req_mem_op_i == MEM_NO) begin
                        // Non-memory instruction: completes without the bus.
                        done_o = 1'b1;
                    end else if (w_misal) begin
                        misaligned_o = 1'b1;
                    end else begin
                        w_accept = 1'b1;
                        stall_o  = 1'b1;
                        state_d  = MS_REQ;
                    end
                end
            end
            MS_REQ: begin
                mem_req_valid_o = 1'b1;
                stall_o         = req_valid_i;
                if (mem_req_ready_i) begin
                    state_d = MS_WAIT;
                end
            end
            MS_WAIT: begin
                stall_o = req_valid_i;
                if (mem_resp_valid_i) begin
                    state_d = MS_DONE;
                end
            end
            MS_DONE: begin
                // Pipeline advances on this edge; the next access is only
                // looked at once we are back in IDLE.
                done_o  = 1'b1;
                state_d = MS_IDLE;
            end
            default: state_d = MS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MS_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            op_q    <= MEM_NO;
            off_q   <= 3'd0;
            wdata_q <= '0;
            wmask_q <= 8'd0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (w_accept) begin
                addr_q  <= {req_addr_i[ADDR_WIDTH-1:3], 3'b000};
                we_q    <= req_we_i;
                op_q    <= req_mem_op_i;
                off_q   <= req_addr_i[2:0];
                wdata_q <= req_we_i ? w_st_data : '0;
                wmask_q <= req_we_i ? w_st_mask : 8'd0;
            end
            // Store acks carry no data; rdata keeps the last load result.
            if (state_q == MS_WAIT && mem_resp_valid_i && !we_q) begin
                rdata_q <= w_ld_data;
            end
        end
    end

    assign mem_addr_o  = addr_q;
    assign mem_we_o    = we_q;
    assign mem_wdata_o = wdata_q;
    assign mem_wmask_o = wmask_q;
    assign rdata_o     = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed self-checking bench for mem_access_unit, with a
//               one-doubleword bus agent model answering requests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    mem_op_enum  req_mem_op = MEM_NO;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        stall, done, misaligned, mem_req_valid, mem_we;
    logic [63:0] rdata, mem_addr, mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_req_ready = 1'b0;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_resp_data = '0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Access observations
    int          n_stall, n_reqv, n_done, first_req, last_req;
    logic        fld_changed, fin;
    logic [63:0] f_addr, f_wdata, last_rdata, bus_mem, m;
    logic [7:0]  f_wmask;
    logic        f_we;
    int          prev_last_req;

    mem_access_unit #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid_i      (req_valid),
        .req_we_i         (req_we),
        .req_mem_op_i     (req_mem_op),
        .req_addr_i       (req_addr),
        .req_wdata_i      (req_wdata),
        .stall_o          (stall),
        .done_o           (done),
        .rdata_o          (rdata),
        .misaligned_o     (misaligned),
        .mem_req_valid_o  (mem_req_valid),
        .mem_req_ready_i  (mem_req_ready),
        .mem_addr_o       (mem_addr),
        .mem_we_o         (mem_we),
        .mem_wdata_o      (mem_wdata),
        .mem_wmask_o      (mem_wmask),
        .mem_resp_valid_i (mem_resp_valid),
        .mem_resp_data_i  (mem_resp_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, act, exp);
        end
    endtask

    task automatic drive_req(input logic we, input mem_op_enum op, input logic [63:0] addr,
                             input logic [63:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_mem_op = op;
        req_addr   = addr;
        req_wdata  = wdata;
    endtask

    // Called just after a rising edge. Runs one access to completion with the
    // bus agent raising ready after rdy_lat REQ cycles and responding in the
    // rsp_lat-th cycle after acceptance; drops req_valid after done.
    task automatic do_access(input logic we, input mem_op_enum op, input logic [63:0] addr,
                             input logic [63:0] wdata, input int rdy_lat, input int rsp_lat);
        logic acc;
        int   wcnt;
        drive_req(we, op, addr, wdata);
        n_stall = 0; n_reqv = 0; n_done = 0; fld_changed = 0; fin = 0;
        acc = 0; wcnt = 0; first_req = -1; last_req = -1;
        for (int c = 0; c < 40 && !fin; c++) begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            if (stall) n_stall++;
            if (mem_req_valid) begin
                if (n_reqv == 0) begin
                    f_addr = mem_addr; f_we = mem_we; f_wdata = mem_wdata; f_wmask = mem_wmask;
                    first_req = cyc;
                end else if (mem_addr !== f_addr || mem_we !== f_we ||
                             mem_wdata !== f_wdata || mem_wmask !== f_wmask) begin
                    fld_changed = 1;
                end
                n_reqv++;
                last_req = cyc;
            end
            if (done) begin
                n_done++;
                last_rdata = rdata;
                fin = 1;
            end
            if (mem_req_ready) begin
                // Request accepted at the last edge: commit stores to the model.
                mem_req_ready = 1'b0;
                acc = 1;
                if (f_we) begin
                    for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{f_wmask[b]}};
                    bus_mem = (bus_mem & ~m) | (f_wdata & m);
                end
            end
            if (acc && !fin) begin
                wcnt++;
                if (wcnt == rsp_lat) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = bus_mem;
                end
            end else if (mem_req_valid && !acc && n_reqv > rdy_lat) begin
                mem_req_ready = 1'b1;
            end
        end
        check_eq("no_timeout", {63'd0, fin}, 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    initial begin
        bus_mem = '0;
        m = '0;
        last_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_stall",  {63'd0, stall}, 64'd0);
        check_eq("rst_done",   {63'd0, done}, 64'd0);
        check_eq("rst_misal",  {63'd0, misaligned}, 64'd0);
        check_eq("rst_reqv",   {63'd0, mem_req_valid}, 64'd0);
        check_eq("rst_we",     {63'd0, mem_we}, 64'd0);
        check_eq("rst_addr",   mem_addr, 64'd0);
        check_eq("rst_wdata",  mem_wdata, 64'd0);
        check_eq("rst_wmask",  {56'd0, mem_wmask}, 64'd0);
        check_eq("rst_rdata",  rdata, 64'd0);
        rst = 1'b0;

        // LB / LBU at 0x1003, byte 0x80
        bus_mem = 64'h0000_0000_8000_0000;
        do_access(1'b0, MEM_B, 64'h1003, 64'd0, 0, 1);
        check_eq("lb_rdata",  last_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        check_eq("lb_stalls", n_stall, 64'd3);
        check_eq("lb_done",   n_done, 64'd1);
        check_eq("lb_addr",   f_addr, 64'h1000);
        check_eq("lb_wmask",  {56'd0, f_wmask}, 64'd0);
        check_eq("lb_we",     {63'd0, f_we}, 64'd0);
        do_access(1'b0, MEM_UB, 64'h1003, 64'd0, 0, 1);
        check_eq("lbu_rdata", last_rdata, 64'h80);

        // SH at 0x2006
        do_access(1'b1, MEM_H, 64'h2006, 64'hABCD, 0, 1);
        check_eq("sh_addr",  f_addr, 64'h2000);
        check_eq("sh_wmask", {56'd0, f_wmask}, 64'hC0);
        check_eq("sh_wdata", f_wdata, 64'hABCD_0000_0000_0000);
        check_eq("sh_we",    {63'd0, f_we}, 64'd1);
        check_eq("sh_done",  n_done, 64'd1);
        check_eq("sh_rdata_held", last_rdata, 64'h80);

        // LW at 0x1002: misaligned
        drive_req(1'b0, MEM_W, 64'h1002, 64'd0);
        @(negedge clk);
        check_eq("mis_flag",  {63'd0, misaligned}, 64'd1);
        check_eq("mis_stall", {63'd0, stall}, 64'd0);
        check_eq("mis_reqv",  {63'd0, mem_req_valid}, 64'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("mis_pulse", {63'd0, misaligned}, 64'd0);
        check_eq("mis_reqv2", {63'd0, mem_req_valid}, 64'd0);
        @(posedge clk); #1;

        // LW / LWU at offset 4
        bus_mem = 64'h8765_4321_0000_0000;
        do_access(1'b0, MEM_W, 64'h5004, 64'd0, 0, 1);
        check_eq("lw_rdata",  last_rdata, 64'hFFFF_FFFF_8765_4321);
        do_access(1'b0, MEM_UW, 64'h5004, 64'd0, 0, 1);
        check_eq("lwu_rdata", last_rdata, 64'h0000_0000_8765_4321);

        // MEM_NO completes immediately
        drive_req(1'b0, MEM_NO, 64'h0, 64'd0);
        @(negedge clk);
        check_eq("no_done",  {63'd0, done}, 64'd1);
        check_eq("no_stall", {63'd0, stall}, 64'd0);
        check_eq("no_reqv",  {63'd0, mem_req_valid}, 64'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;

        // LD with ready delayed 4 cycles, response 2 cycles after acceptance
        bus_mem = 64'h0123_4567_89AB_CDEF;
        do_access(1'b0, MEM_D, 64'h3000, 64'd0, 4, 2);
        check_eq("ld_reqv_cycles", n_reqv, 64'd5);
        check_eq("ld_fields_stable", {63'd0, fld_changed}, 64'd0);
        check_eq("ld_stalls", n_stall, 64'd8);
        check_eq("ld_done",   n_done, 64'd1);
        check_eq("ld_rdata",  last_rdata, 64'h0123_4567_89AB_CDEF);
        @(negedge clk);
        check_eq("ld_done_pulse", {63'd0, done}, 64'd0);
        @(posedge clk); #1;

        // Back-to-back SD then LD at 0x4000
        bus_mem = '0;
        do_access(1'b1, MEM_D, 64'h4000, 64'h1122_3344_5566_7788, 0, 1);
        check_eq("sd_wmask", {56'd0, f_wmask}, 64'hFF);
        check_eq("sd_wdata", f_wdata, 64'h1122_3344_5566_7788);
        prev_last_req = last_req;
        do_access(1'b0, MEM_D, 64'h4000, 64'd0, 0, 1);
        check_eq("b2b_ld_rdata", last_rdata, 64'h1122_3344_5566_7788);
        // REQ, WAIT, DONE, IDLE, REQ: next REQ is 4 cycles after the last one
        check_eq("b2b_gap", first_req - prev_last_req, 64'd4);

        // Reset while in WAIT, then a stale response
        drive_req(1'b0, MEM_D, 64'h3000, 64'd0);
        @(negedge clk);
        @(negedge clk);
        check_eq("rw_reqv", {63'd0, mem_req_valid}, 64'd1);
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        rst = 1'b1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hDEAD_BEEF_DEAD_BEEF;
        check_eq("rw_done0", {63'd0, done}, 64'd0);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        check_eq("rw_done1", {63'd0, done}, 64'd0);
        check_eq("rw_rdata", rdata, 64'd0);
        check_eq("rw_reqv2", {63'd0, mem_req_valid}, 64'd0);
        check_eq("rw_addr",  mem_addr, 64'd0);
        @(negedge clk);
        check_eq("rw_done2", {63'd0, done}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access engine for the pipelined RV64 core. It consumes the decoder's memory controls (`we_mem`, `re_mem`, `mem_op`) plus the ALU-computed address and the rs2 store data. It issues one byte-masked, doubleword-aligned request per access on the data bus, waits for the response, and returns sign- or zero-extended load data. It stalls the pipeline until the access completes and flags misaligned accesses instead of issuing them.

## Interface
- `ADDR_WIDTH`, default 64: byte address width.
- `DATA_WIDTH`, default 64: bus data width, fixed at 64; byte lanes = 8.
- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: MEM stage holds a load or store (`re_mem | we_mem`).
- `req_we` in 1: 1 = store, 0 = load.
- `req_mem_op` in `CorePack::mem_op_enum`: access size and signedness.
- `req_addr` in ADDR_WIDTH: byte address.
- `req_wdata` in 64: store data, LSB-justified.
- `stall` out 1: hold IF/ID/EX/MEM.
- `done` out 1: one-cycle pulse when the access completes.
- `rdata` out 64: extended load result, valid while `done`.
- `misaligned` out 1: one-cycle pulse, access not naturally aligned.
- `mem_req_valid` out 1, `mem_req_ready` in 1: request handshake.
- `mem_addr` out ADDR_WIDTH: `{req_addr[ADDR_WIDTH-1:3], 3'b0}`.
- `mem_we` out 1, `mem_wdata` out 64, `mem_wmask` out 8: write controls.
- `mem_resp_valid` in 1, `mem_resp_data` in 64: response; one response per accepted request, stores included as an ack.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - `req_valid` and aligned and `mem_op != MEM_NO`: register addr, we, op, shifted wdata and mask, then go to REQ. `stall=1`.
  - `req_valid` and misaligned: `misaligned=1` for this cycle, `stall=0`, no bus traffic, stay IDLE.
  - `req_valid` and `MEM_NO`: `done=1` combinationally, `stall=0`, stay IDLE.
- **REQ**: `mem_req_valid=1` with registered fields. On `mem_req_ready`, go to WAIT. Outputs are held stable until accepted.
- **WAIT**: `mem_req_valid=0`. On `mem_resp_valid`, capture the extended data into the `rdata` register and go to DONE.
- **DONE**: `done=1`, `stall=0`. The pipeline advances at this edge. Next state is IDLE unconditionally, and the new `req_valid` is sampled in IDLE on the following cycle.
- `stall = req_valid & (state != DONE) & ~(state==IDLE & (misaligned | op==MEM_NO))`.
- Alignment rules:
  - B/UB: always aligned.
  - H/UH: `addr[0]==0`.
  - W/UW: `addr[1:0]==0`.
  - D: `addr[2:0]==0`.
- Mask and data placement, with `off = addr[2:0]`:
  - `mem_wmask = ((1<<bytes)-1) << off`
  - `mem_wdata = req_wdata << 8*off`
  - Loads drive `mem_wmask=0`.
- Load extraction: `raw = mem_resp_data >> 8*off`, then truncate to the access width. B/H/W sign-extend to 64; UB/UH/UW/D zero-extend.
- A response arriving in IDLE, REQ or DONE is ignored.
- Reset mid-operation: return to IDLE and drop the outstanding access. The bus agent is reset by the same `rst`.

## Timing
- Reset values:
  - State IDLE.
  - `stall`, `done`, `misaligned`, `mem_req_valid`, `mem_we` = 0.
  - `mem_addr`, `mem_wdata`, `mem_wmask`, `rdata` = 0.
- Minimum latency (ready in the first REQ cycle, response in the cycle after acceptance): request seen at cycle 0, REQ at cycle 1, WAIT at cycle 2, DONE at cycle 3. That is 3 stall cycles, then 1 `done` cycle.
- A response in the same cycle as acceptance is not legal; the bus agent responds at least 1 cycle after.
- Back-to-back accesses: at least 1 IDLE cycle between DONE and the next REQ.
- `rdata` holds its value until the next load completes.

## Structure
- Add to `CorePack`:
  - `mem_fsm_state_enum` (IDLE/REQ/WAIT/DONE).
  - `MEM_BYTES` function or constant map from `mem_op_enum` to bytes (1/2/4/8).
- Reuse the existing `mem_op_enum`.
- Sub-module `mem_data_align` (combinational):
  - Store path: op + offset + wdata → mask, shifted data.
  - Load path: op + offset + resp data → extended rdata.
  - Misalignment check.

## Test plan
- LB at `0x1003`, resp `0x0000_0000_8000_0000`: byte `0x80` → `rdata=0xFFFF_FFFF_FFFF_FF80`. LBU on the same access → `0x80`.
- SH at `0x2006`, wdata `0xABCD`: `mem_addr=0x2000`, `mem_wmask=0xC0`, `mem_wdata=0xABCD_0000_0000_0000`, `mem_we=1`; `done` follows the ack.
- LW at `0x1002`: `misaligned=1` for one cycle, `mem_req_valid` never rises, `stall=0`.
- LD at `0x3000` with `mem_req_ready` low for 4 cycles and response 2 cycles after acceptance: `mem_req_valid` held for 5 cycles with stable fields; `stall` high through WAIT; `done` exactly one cycle.
- `rst` asserted in WAIT, then a stale `mem_resp_valid` pulse: FSM returns to IDLE, `done` stays 0, `rdata=0`.
- Back-to-back SD then LD at `0x4000`: LD returns the SD data `0x1122_3344_5566_7788`, and one IDLE cycle separates the two REQ phases.
